musb_dma: RTL and testbench

Single-channel word-copy DMA engine for the MUSB SoC bus. It has two ports on the bus. The slave port holds four configuration/status registers. The master port issues its own read and write transactions through the arbiter, on the same address/data/wr/enable/ready/error protocol the core and bootloader use. It copies LEN 32-bit words from SRC to DST and raises a level interrupt on completion or bus error.

---
 rtl/musb_dma.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_musb_dma.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/musb_dma.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// musb_dma
// Single-channel word-copy DMA engine for the MUSB SoC bus. It copies LEN
// 32-bit words from SRC to DST, one read followed by one write per word, and
// raises a level interrupt on completion or on a bus error.
//
// Ports
//   clk, rst                 bus clock (rising edge), async active-low reset
//   dma_address/_data_i/_wr  slave register access: offset[3:2] selects
//   dma_enable               SRC, DST, LEN or CTRL/STAT; any nonzero
//                            dma_wr is a full-word write
//   dma_data_o, dma_ready    registered read data and one-cycle completion
//   master_address/_data_o   bus master request (word aligned), held
//   master_wr/_enable        stable for as long as master_enable is high
//   master_data_i/_ready     bus master response; error has priority
//   master_error             over ready
//   dma_interrupt            IE & (DONE | ERR)
// ---------------------------------------------------------------------------
module musb_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           dma_address,
  input  logic [31:0]          dma_data_i,
  input  logic [3:0]           dma_wr,
  input  logic                 dma_enable,
  output logic [31:0]          dma_data_o,
  output logic                 dma_ready,
  output logic [31:0]          master_address,
  output logic [31:0]          master_data_o,
  output logic [3:0]           master_wr,
  output logic                 master_enable,
  input  logic [31:0]          master_data_i,
  input  logic                 master_ready,
  input  logic                 master_error,
  output logic                 dma_interrupt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_GAP = 3'd1,
    READ   = 3'd2,
    WR_GAP = 3'd3,
    WRITE  = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r, state_s;
  // Addresses are kept as word addresses; bits [1:0] are always zero.
  logic [29:0]          src_r, src_s;
  logic [29:0]          dst_r, dst_s;
  logic [LEN_WIDTH-1:0] len_r, len_s;
  logic [31:0]          buf_r, buf_s;
  logic                 ie_r, ie_s;
  logic                 done_r, done_s;
  logic                 err_r, err_s;

  logic                 ready_r;
  logic [31:0]          rdata_r, rdata_s;
  logic [31:0]          m_addr_r, m_addr_s;
  logic [31:0]          m_data_r, m_data_s;
  logic [3:0]           m_wr_r, m_wr_s;
  logic                 m_en_r, m_en_s;
  logic                 irq_r, irq_s;

  logic                 acc_s;
  logic                 wr_acc_s;
  logic                 busy_s;
  logic                 start_s;
  logic [31:0]          len_ext_s;
  logic [1:0]           unused_addr_s;

  // A slave access is taken on any edge where it is requested and the
  // previous one is not still being acknowledged.
  assign acc_s         = dma_enable & ~ready_r;
  assign wr_acc_s      = acc_s & (dma_wr != 4'h0);
  assign busy_s        = (state_r != IDLE);
  assign unused_addr_s = dma_address[1:0];

  // Register writes from the slave port, then FSM updates (FSM sets win).
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    len_s   = len_r;
    buf_s   = buf_r;
    ie_s    = ie_r;
    done_s  = done_r;
    err_s   = err_r;
    start_s = 1'b0;

    if (wr_acc_s) begin
      case (dma_address[3:2])
        2'd0: begin
          if (!busy_s) begin
            src_s = dma_data_i[31:2];
          end else begin
            src_s = src_r;
          end
        end
        2'd1: begin
          if (!busy_s) begin
            dst_s = dma_data_i[31:2];
          end else begin
            dst_s = dst_r;
          end
        end
        2'd2: begin
          if (!busy_s) begin
            len_s = dma_data_i[LEN_WIDTH-1:0];
          end else begin
            len_s = len_r;
          end
        end
        2'd3: begin
          ie_s = dma_data_i[3];
          if (dma_data_i[1]) begin
            done_s = 1'b0;
          end else begin
            done_s = done_r;
          end
          if (dma_data_i[2]) begin
            err_s = 1'b0;
          end else begin
            err_s = err_r;
          end
          start_s = dma_data_i[0] & ~busy_s;
        end
        default: begin
          start_s = 1'b0;
        end
      endcase
    end else begin
      start_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (start_s) begin
          done_s = 1'b0;
          err_s  = 1'b0;
          // An empty transfer completes at once without touching the bus.
          if (len_r == LEN_ZERO) begin
            done_s = 1'b1;
          end else begin
            state_s = RD_GAP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_GAP: begin
        state_s = READ;
      end
      READ: begin
        if (master_error) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else if (master_ready) begin
          buf_s   = master_data_i;
          state_s = WR_GAP;
        end else begin
          state_s = READ;
        end
      end
      WR_GAP: begin
        state_s = WRITE;
      end
      WRITE: begin
        if (master_error) begin
          // Pointers and count stay at the failed word.
          state_s = IDLE;
          err_s   = 1'b1;
        end else if (master_ready) begin
          src_s = src_r + 30'd1;
          dst_s = dst_r + 30'd1;
          len_s = len_r - LEN_ONE;
          if (len_r == LEN_ONE) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RD_GAP;
          end
        end else begin
          state_s = WRITE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered bus request: loaded on entry to READ/WRITE so it stays stable
  // while enable is high, and enable drops right after ready/error.
  always_comb begin
    m_en_s   = (state_s == READ) || (state_s == WRITE);
    m_wr_s   = (state_s == WRITE) ? 4'hF : 4'h0;
    m_addr_s = m_addr_r;
    m_data_s = m_data_r;
    if (state_s == READ) begin
      m_addr_s = {src_s, 2'b00};
    end else if (state_s == WRITE) begin
      m_addr_s = {dst_s, 2'b00};
      m_data_s = buf_s;
    end else begin
      m_addr_s = m_addr_r;
    end
    irq_s = ie_s & (done_s | err_s);
  end

  // Slave read mux; values are those before the accepting edge.
  always_comb begin
    len_ext_s                  = 32'h0000_0000;
    len_ext_s[LEN_WIDTH-1:0]   = len_r;
    rdata_s                    = rdata_r;
    if (acc_s) begin
      case (dma_address[3:2])
        2'd0:    rdata_s = {src_r, 2'b00};
        2'd1:    rdata_s = {dst_r, 2'b00};
        2'd2:    rdata_s = len_ext_s;
        2'd3:    rdata_s = {28'h000_0000, ie_r, err_r, done_r, busy_s};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = rdata_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Configuration, status and data buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_r  <= 30'd0;
      dst_r  <= 30'd0;
      len_r  <= LEN_ZERO;
      buf_r  <= 32'h0000_0000;
      ie_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      src_r  <= src_s;
      dst_r  <= dst_s;
      len_r  <= len_s;
      buf_r  <= buf_s;
      ie_r   <= ie_s;
      done_r <= done_s;
      err_r  <= err_s;
    end
  end

  // Output registers for the slave port, master port and interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r  <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      m_addr_r <= 32'h0000_0000;
      m_data_r <= 32'h0000_0000;
      m_wr_r   <= 4'h0;
      m_en_r   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      ready_r  <= acc_s;
      rdata_r  <= rdata_s;
      m_addr_r <= m_addr_s;
      m_data_r <= m_data_s;
      m_wr_r   <= m_wr_s;
      m_en_r   <= m_en_s;
      irq_r    <= irq_s;
    end
  end

  assign dma_ready      = ready_r;
  assign dma_data_o     = rdata_r;
  assign master_address = m_addr_r;
  assign master_data_o  = m_data_r;
  assign master_wr      = m_wr_r;
  assign master_enable  = m_en_r;
  assign dma_interrupt  = irq_r;

endmodule

// File: tb/tb_musb_dma.sv
`timescale 1ns/1ps
// Self-checking bench for musb_dma: a bus memory model with optional random
// stalls answers the master port; expectations come from the copy rules.
module tb_musb_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  dma_address = 4'h0;
  logic [31:0] dma_data_i = 32'h0;
  logic [3:0]  dma_wr = 4'h0;
  logic        dma_enable = 1'b0;
  logic [31:0] dma_data_o;
  logic        dma_ready;
  logic [31:0] master_address;
  logic [31:0] master_data_o;
  logic [3:0]  master_wr;
  logic        master_enable;
  logic [31:0] master_data_i;
  logic        master_ready;
  logic        master_error;
  logic        dma_interrupt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  musb_dma #(.LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .dma_address(dma_address), .dma_data_i(dma_data_i), .dma_wr(dma_wr),
    .dma_enable(dma_enable), .dma_data_o(dma_data_o), .dma_ready(dma_ready),
    .master_address(master_address), .master_data_o(master_data_o),
    .master_wr(master_wr), .master_enable(master_enable),
    .master_data_i(master_data_i), .master_ready(master_ready),
    .master_error(master_error), .dma_interrupt(dma_interrupt)
  );

  // Memory: 0x0000_0000..0x0000_0FFF and 0xFFFF_F000..0xFFFF_FFFF mapped.
  logic [31:0] mem [0:2047];
  logic        stall_en = 1'b0;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = 32'h0;
  logic [31:0] bd_data = 32'h0;

  function automatic bit mapped(input logic [31:0] a);
    return (a[31:12] == 20'h00000) || (a[31:12] == 20'hFFFFF);
  endfunction

  function automatic logic [10:0] midx(input logic [31:0] a);
    return {a[31], a[11:2]};
  endfunction

  always @(posedge clk) begin
    if (bd_we) mem[midx(bd_addr)] <= bd_data;
    if (master_enable && !master_ready && !master_error &&
        (!stall_en || ($urandom_range(0, 1) == 1))) begin
      if (!mapped(master_address)) begin
        master_error <= 1'b1;
      end else begin
        master_ready <= 1'b1;
        if (master_wr == 4'hF) mem[midx(master_address)] <= master_data_o;
        else master_data_i <= mem[midx(master_address)];
      end
    end else begin
      master_ready <= 1'b0;
      master_error <= 1'b0;
    end
  end

  // Cycle monitor for bus timing.
  int  cyc = 0;
  int  en_cnt, first_en, irq_at;
  logic mon_clr = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mon_clr) begin
      en_cnt <= 0; first_en <= -1; irq_at <= -1;
    end else begin
      if (master_enable) en_cnt <= en_cnt + 1;
      if (master_enable && first_en < 0) first_en <= cyc;
      if (dma_interrupt && irq_at < 0) irq_at <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic [3:0] a, input bit w, input logic [31:0] d,
                        output logic [31:0] q);
    bit got = 1'b0;
    @(negedge clk);
    dma_address = a; dma_wr = w ? 4'hF : 4'h0; dma_data_i = d; dma_enable = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (dma_ready) got = 1'b1;
    end
    q = dma_data_o;
    dma_enable = 1'b0; dma_wr = 4'h0;
    checks++;
    assert (got === 1'b1) else begin
      errors++;
      $error("FAIL slave_ready: observed=%b expected=1", got);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    access(a, 1'b1, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    access(a, 1'b0, 32'h0, q);
    chk(tag, q, exp);
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      access(4'hC, 1'b0, 32'h0, q);
      if (q[0] == 1'b0) idle = 1'b1;
    end
    checks++;
    assert (idle === 1'b1) else begin
      errors++;
      $error("FAIL wait_idle: observed busy=1 expected busy=0 within bound");
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] sbase, dbase, v;
    int n;
    bit seen;

    // Reset defaults
    #2;
    chk("rst_en", {31'd0, master_enable}, 32'd0);
    chk("rst_wr", {28'd0, master_wr}, 32'd0);
    chk("rst_addr", master_address, 32'd0);
    chk("rst_wdata", master_data_o, 32'd0);
    chk("rst_ready", {31'd0, dma_ready}, 32'd0);
    chk("rst_rdata", dma_data_o, 32'd0);
    chk("rst_irq", {31'd0, dma_interrupt}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd_chk("rst_src", 4'h0, 32'd0);
    rd_chk("rst_dst", 4'h4, 32'd0);
    rd_chk("rst_len", 4'h8, 32'd0);
    rd_chk("rst_ctrl", 4'hC, 32'd0);

    // Basic copy, with low address bits discarded and offset bits [1:0] ignored
    for (int i = 0; i < 4; i++) poke(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    wr_reg(4'h0, 32'h0000_0103);
    rd_chk("src_lowbits", 4'h0, 32'h0000_0100);
    wr_reg(4'h6, 32'h0000_0200);
    wr_reg(4'h8, 32'd4);
    clear_mon();
    wr_reg(4'hC, 32'h9);
    wait_idle();
    for (int i = 0; i < 4; i++)
      chk("copy_data", mem[midx(32'h200 + 32'(4 * i))], 32'hA0 + 32'(i));
    rd_chk("copy_ctrl", 4'hC, 32'hA);
    chk("copy_irq", {31'd0, dma_interrupt}, 32'd1);
    rd_chk("copy_src", 4'h0, 32'h110);
    rd_chk("copy_dst", 4'h4, 32'h210);
    rd_chk("copy_len", 4'h8, 32'd0);
    chk("copy_en_cycles", en_cnt, 32'd16);
    chk("copy_span", irq_at - first_en + 1, 32'd24);

    // LEN=0 start
    wr_reg(4'h8, 32'd0);
    clear_mon();
    wr_reg(4'hC, 32'h9);
    rd_chk("len0_ctrl", 4'hC, 32'hA);
    chk("len0_irq", {31'd0, dma_interrupt}, 32'd1);
    chk("len0_no_bus", en_cnt, 32'd0);
    wr_reg(4'hC, 32'h2);
    chk("w1c_irq", {31'd0, dma_interrupt}, 32'd0);
    rd_chk("w1c_ctrl", 4'hC, 32'h0);

    // Error abort on first write
    poke(32'h400, 32'h55);
    wr_reg(4'h0, 32'h400);
    wr_reg(4'h4, 32'h8000_0000);
    wr_reg(4'h8, 32'd1);
    wr_reg(4'hC, 32'h9);
    wait_idle();
    rd_chk("err_ctrl", 4'hC, 32'hC);
    chk("err_irq", {31'd0, dma_interrupt}, 32'd1);
    rd_chk("err_len", 4'h8, 32'd1);
    rd_chk("err_dst", 4'h4, 32'h8000_0000);
    rd_chk("err_src", 4'h0, 32'h400);

    // Busy protection
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      exp_q.push_back(v);
      poke(32'h500 + 32'(4 * i), v);
    end
    wr_reg(4'h0, 32'h500);
    wr_reg(4'h4, 32'h600);
    wr_reg(4'h8, 32'd3);
    clear_mon();
    wr_reg(4'hC, 32'h9);
    rd_chk("busy_ctrl", 4'hC, 32'h9);
    wr_reg(4'h0, 32'h0000_DEAD);
    wr_reg(4'hC, 32'h9);
    wait_idle();
    for (int i = 0; i < 3; i++)
      chk("busy_data", mem[midx(32'h600 + 32'(4 * i))], exp_q[i]);
    rd_chk("busy_src", 4'h0, 32'h50C);
    rd_chk("busy_dst", 4'h4, 32'h60C);
    rd_chk("busy_done", 4'hC, 32'hA);
    chk("busy_single", en_cnt, 32'd12);

    // DONE set by the FSM wins over a W1C on the same edge
    poke(32'h700, 32'h1234_5678);
    wr_reg(4'h0, 32'h700);
    wr_reg(4'h4, 32'h710);
    wr_reg(4'h8, 32'd1);
    wr_reg(4'hC, 32'h9);
    repeat (5) @(posedge clk);
    #1;
    dma_address = 4'hC; dma_wr = 4'hF; dma_data_i = 32'hA; dma_enable = 1'b1;
    @(posedge clk); #1;
    chk("setwin_accept", {31'd0, dma_ready}, 32'd1);
    dma_enable = 1'b0; dma_wr = 4'h0;
    rd_chk("setwin_ctrl", 4'hC, 32'hA);
    chk("setwin_data", mem[midx(32'h710)], 32'h1234_5678);

    // Address wrap 0xFFFF_FFFC -> 0
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      exp_q.push_back(v);
      poke(32'hFFFF_FFF8 + 32'(4 * i), v);
    end
    wr_reg(4'h0, 32'hFFFF_FFF8);
    wr_reg(4'h4, 32'h800);
    wr_reg(4'h8, 32'd3);
    wr_reg(4'hC, 32'h1);
    wait_idle();
    for (int i = 0; i < 3; i++)
      chk("wrap_data", mem[midx(32'h800 + 32'(4 * i))], exp_q[i]);
    rd_chk("wrap_src", 4'h0, 32'h4);
    rd_chk("wrap_dst", 4'h4, 32'h80C);

    // Random transfers with bus stalls, IE=0
    stall_en = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 8));
      sbase = 32'hA00 + 32'(t * 32'h40);
      dbase = 32'hC00 + 32'(t * 32'h40);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        exp_q.push_back(v);
        poke(sbase + 32'(4 * i), v);
      end
      wr_reg(4'h0, sbase);
      wr_reg(4'h4, dbase);
      wr_reg(4'h8, 32'(n));
      wr_reg(4'hC, 32'h1);
      wait_idle();
      for (int i = 0; i < n; i++)
        chk("rand_data", mem[midx(dbase + 32'(4 * i))], exp_q[i]);
      rd_chk("rand_src", 4'h0, sbase + 32'(4 * n));
      rd_chk("rand_dst", 4'h4, dbase + 32'(4 * n));
      rd_chk("rand_len", 4'h8, 32'd0);
      rd_chk("rand_ctrl", 4'hC, 32'h2);
      chk("rand_irq", {31'd0, dma_interrupt}, 32'd0);
    end
    stall_en = 1'b0;

    // Reset during WRITE
    wr_reg(4'h0, 32'h100);
    wr_reg(4'h4, 32'hE00);
    wr_reg(4'h8, 32'd4);
    wr_reg(4'hC, 32'h9);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (master_enable && master_wr == 4'hF) seen = 1'b1;
    end
    chk("midrst_reach_write", {31'd0, seen}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_en", {31'd0, master_enable}, 32'd0);
    chk("midrst_wr", {28'd0, master_wr}, 32'd0);
    chk("midrst_irq", {31'd0, dma_interrupt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd_chk("midrst_src", 4'h0, 32'd0);
    rd_chk("midrst_dst", 4'h4, 32'd0);
    rd_chk("midrst_len", 4'h8, 32'd0);
    rd_chk("midrst_ctrl", 4'hC, 32'd0);
    chk("midrst_en_after", {31'd0, master_enable}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
